// File: rtl/adder_nibble_seq.sv
// Nibble-serial add/subtract sequencer built on two 4-bit carry-lookahead slices.
// Each nibble is held for SETTLE_CYCLES clocks before its sum and carry are captured.

module adder_cla_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | ((&p) & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];
endmodule

module adder_nibble_seq #(
   parameter int WIDTH         = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int N     = WIDTH / 4;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, b_reg;
   logic               carry_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               cout_reg, overflow_reg;
   logic               capture, last_nib;

   logic [3:0]         s1_sum, slice_sum;
   logic               s1_co, s2_co, slice_co;

   // Slice 1 adds the operand nibbles; slice 2 folds in the running carry.
   adder_cla_4 u_slice1 (
      .a  (a_reg[3:0]),
      .b  (b_reg[3:0]),
      .ci (1'b0),
      .s  (s1_sum),
      .co (s1_co)
   );

   adder_cla_4 u_slice2 (
      .a  (s1_sum),
      .b  (4'd0),
      .ci (carry_reg),
      .s  (slice_sum),
      .co (s2_co)
   );

   assign slice_co = s1_co | s2_co;
   assign last_nib = (idx_reg == IDX_W'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = SETTLE;
         end
         SETTLE: begin
            busy = 1'b1;
            if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) state_next = CAPTURE;
         end
         CAPTURE: begin
            busy       = 1'b1;
            capture    = 1'b1;
            state_next = last_nib ? DONE : SETTLE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg        <= '0;
         b_reg        <= '0;
         carry_reg    <= 1'b0;
         idx_reg      <= '0;
         cnt_reg      <= '0;
         cout_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= sub ? ~op_b : op_b;
                  carry_reg <= sub ? 1'b1 : cin;
                  idx_reg   <= '0;
                  cnt_reg   <= '0;
               end
            end
            SETTLE: cnt_reg <= cnt_reg + CNT_W'(1);
            CAPTURE: begin
               carry_reg <= slice_co;
               a_reg     <= a_reg >> 4;
               b_reg     <= b_reg >> 4;
               if (last_nib) begin
                  cout_reg     <= slice_co;
                  // Top nibble is in the low bits of the operand registers here.
                  overflow_reg <= (a_reg[3] == b_reg[3]) && (slice_sum[3] != a_reg[3]);
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
                  cnt_reg <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_nib
         logic [3:0] nib_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                   nib_reg <= 4'd0;
            else if (capture && idx_reg == IDX_W'(gi))    nib_reg <= slice_sum;
         end
         assign sum[4*gi +: 4] = nib_reg;
      end
   endgenerate

   assign cout     = cout_reg;
   assign overflow = overflow_reg;
endmodule
